// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl_fsm
//  Purpose  : Sequences an 8-way, 16-set TagMemory for one CPU access at a
//             time: lookup, hit LRU/dirty update, dirty-victim write-back,
//             line fill, tag allocation. Keeps saturating hit/miss counters.
//  Ports    : clk, rst (async, active-high)
//             cpu_*  : request {tag,index}, busy/done handshake, hit + way
//             tm_*   : TagMemory index/tag drive, wr/mod/age pulses, and
//                      lookup results (hit way, LRU victim way/tag/dirty)
//             mem_*  : next-level request, write-back vs fill, line address,
//                      completion ack
//             hit_cnt, miss_cnt : saturating statistics
//  Revision : 1.0  initial release
// ============================================================================
module cache_ctrl_fsm #(
   parameter int TAG_W = 8,
   parameter int IDX_W = 4,
   parameter int WAY_W = 3,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [TAG_W+IDX_W-1:0] cpu_addr,
   output logic                   cpu_busy,
   output logic                   cpu_done,
   output logic                   cpu_hit,
   output logic [WAY_W-1:0]       cpu_way,
   output logic [TAG_W-1:0]       tm_tag,
   output logic [IDX_W-1:0]       tm_index,
   output logic                   tm_wr,
   output logic                   tm_mod,
   output logic                   tm_age,
   input  logic                   tm_hit,
   input  logic [WAY_W-1:0]       tm_chan,
   input  logic [WAY_W-1:0]       tm_age_chan,
   input  logic [TAG_W-1:0]       tm_age_tag,
   input  logic                   tm_age_mod,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [TAG_W+IDX_W-1:0] mem_addr,
   input  logic                   mem_ack,
   output logic [CNT_W-1:0]       hit_cnt,
   output logic [CNT_W-1:0]       miss_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_COMPARE = 3'd2;
   localparam logic [2:0] S_WB      = 3'd3;
   localparam logic [2:0] S_FILL    = 3'd4;
   localparam logic [2:0] S_ALLOC   = 3'd5;
   localparam logic [2:0] S_TOUCH   = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]       state;
   logic [2:0]       state_nx;

   logic [TAG_W-1:0] tag_lat;
   logic [IDX_W-1:0] idx_lat;
   logic             we_lat;
   logic             hit_lat;
   logic [WAY_W-1:0] way_lat;
   logic [TAG_W-1:0] vtag_lat;
   // Set after the mark-dirty cycle of a write TOUCH so the second TOUCH
   // cycle issues the age pulse instead.
   logic             mod_done;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // Request latch, lookup capture, TOUCH phase and statistics
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_lat  <= '0;
         idx_lat  <= '0;
         we_lat   <= 1'b0;
         hit_lat  <= 1'b0;
         way_lat  <= '0;
         vtag_lat <= '0;
         mod_done <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (state == S_IDLE && cpu_req) begin
            tag_lat <= cpu_addr[TAG_W+IDX_W-1:IDX_W];
            idx_lat <= cpu_addr[IDX_W-1:0];
            we_lat  <= cpu_we;
         end
         if (state == S_COMPARE) begin
            hit_lat  <= tm_hit;
            // On a miss the line will be allocated into the LRU victim way,
            // so that is the way reported back to the CPU.
            way_lat  <= tm_hit ? tm_chan : tm_age_chan;
            vtag_lat <= tm_age_tag;
            if (tm_hit) begin
               if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
               if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
         end
         mod_done <= (state == S_TOUCH) && we_lat && !mod_done;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (cpu_req) state_nx = S_LOOKUP;
         S_LOOKUP:  state_nx = S_COMPARE;
         S_COMPARE: begin
            if (tm_hit)          state_nx = S_TOUCH;
            else if (tm_age_mod) state_nx = S_WB;
            else                 state_nx = S_FILL;
         end
         S_WB:      if (mem_ack) state_nx = S_FILL;
         S_FILL:    if (mem_ack) state_nx = S_ALLOC;
         S_ALLOC:   state_nx = S_TOUCH;
         S_TOUCH:   if (!(we_lat && !mod_done)) state_nx = S_DONE;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      cpu_busy = (state != S_IDLE);
      cpu_done = 1'b0;
      cpu_hit  = 1'b0;
      cpu_way  = '0;
      tm_tag   = tag_lat;
      tm_index = idx_lat;
      tm_wr    = 1'b0;
      tm_mod   = 1'b0;
      tm_age   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      case (state)
         S_WB: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {vtag_lat, idx_lat};
         end
         S_FILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag_lat, idx_lat};
         end
         S_ALLOC: tm_wr = 1'b1;
         S_TOUCH: begin
            if (we_lat && !mod_done) tm_mod = 1'b1;
            else                     tm_age = 1'b1;
         end
         S_DONE: begin
            cpu_done = 1'b1;
            cpu_hit  = hit_lat;
            cpu_way  = way_lat;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_ctrl_fsm
//  Purpose  : Self-checking bench for cache_ctrl_fsm. Provides a behavioural
//             TagMemory and a next-level memory responder; expected results
//             come from an abstract LRU cache model and are queued per
//             request, then matched against cpu_done events by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_ctrl_fsm;

   localparam int TB_CNT_W = 6;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [11:0] cpu_addr;
   logic        cpu_busy, cpu_done, cpu_hit;
   logic [2:0]  cpu_way;
   logic [7:0]  tm_tag;
   logic [3:0]  tm_index;
   logic        tm_wr, tm_mod, tm_age;
   logic        tm_hit;
   logic [2:0]  tm_chan, tm_age_chan;
   logic [7:0]  tm_age_tag;
   logic        tm_age_mod;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic        mem_ack;
   logic [TB_CNT_W-1:0] hit_cnt, miss_cnt;

   cache_ctrl_fsm #(.TAG_W(8), .IDX_W(4), .WAY_W(3), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_way(cpu_way),
      .tm_tag(tm_tag), .tm_index(tm_index), .tm_wr(tm_wr), .tm_mod(tm_mod), .tm_age(tm_age),
      .tm_hit(tm_hit), .tm_chan(tm_chan), .tm_age_chan(tm_age_chan),
      .tm_age_tag(tm_age_tag), .tm_age_mod(tm_age_mod),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural TagMemory (timestamp LRU) ----------------
   logic       ev [16][8];
   logic [7:0] et [16][8];
   logic       ed [16][8];
   int         stp[16][8];
   int         gstamp;
   logic       e_hit, e_vfound;
   logic [2:0] e_chan, e_vw;
   int         e_best;

   always_comb begin
      e_hit = 1'b0; e_chan = 3'd0; e_vfound = 1'b0; e_vw = 3'd0; e_best = 0;
      for (int w = 0; w < 8; w++)
         if (ev[tm_index][w] && et[tm_index][w] == tm_tag && !e_hit) begin
            e_hit = 1'b1; e_chan = 3'(w);
         end
      for (int w = 0; w < 8; w++)
         if (!ev[tm_index][w] && !e_vfound) begin
            e_vfound = 1'b1; e_vw = 3'(w);
         end
      if (!e_vfound) begin
         e_best = stp[tm_index][0];
         for (int w = 1; w < 8; w++)
            if (stp[tm_index][w] < e_best) begin
               e_best = stp[tm_index][w]; e_vw = 3'(w);
            end
      end
      tm_hit      = e_hit;
      tm_chan     = e_chan;
      tm_age_chan = e_vw;
      tm_age_tag  = et[tm_index][e_vw];
      tm_age_mod  = ed[tm_index][e_vw] & ev[tm_index][e_vw];
   end

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int s = 0; s < 16; s++)
               for (int w = 0; w < 8; w++) begin
                  ev[s][w] <= 1'b0; et[s][w] <= 8'd0; ed[s][w] <= 1'b0; stp[s][w] <= 0;
               end
            gstamp <= 0;
         end else begin
            if (tm_wr) begin
               ev[tm_index][e_vw] <= 1'b1;
               et[tm_index][e_vw] <= tm_tag;
               ed[tm_index][e_vw] <= 1'b0;
            end
            if (tm_mod && e_hit) ed[tm_index][e_chan] <= 1'b1;
            if (tm_age && e_hit) begin
               gstamp <= gstamp + 1;
               stp[tm_index][e_chan] <= gstamp + 1;
            end
         end
      end
   end

   // ---------------- next-level memory responder ----------------
   int fill_d = 1, wb_d = 1;
   int ack_cnt = 0;
   bit prev_act = 0, prev_we = 0;

   initial begin
      mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!mem_req) begin
            ack_cnt = 0; prev_act = 0; mem_ack = 1'b0;
         end else begin
            if (prev_act && prev_we == mem_we) ack_cnt++;
            else ack_cnt = 1;
            mem_ack  = (ack_cnt >= (mem_we ? wb_d : fill_d));
            prev_we  = mem_we;
            prev_act = 1;
         end
      end
   end

   // ---------------- reference cache model ----------------
   typedef struct {
      int hit; int way; int lat; int seq; int nph; int ph0; int ph1; int hc; int mc;
   } exp_t;
   exp_t exp_q[$];

   bit rv[16][8];
   int rt[16][8];
   bit rd[16][8];
   int ord[16][$];
   int ref_hit = 0, ref_miss = 0;

   task automatic ref_init();
      for (int s = 0; s < 16; s++) begin
         ord[s].delete();
         for (int w = 0; w < 8; w++) begin
            rv[s][w] = 0; rt[s][w] = 0; rd[s][w] = 0; ord[s].push_back(w);
         end
      end
   endtask

   task automatic make_mru(input int s, input int w);
      for (int i = 0; i < ord[s].size(); i++)
         if (ord[s][i] == w) begin ord[s].delete(i); break; end
      ord[s].push_back(w);
   endtask

   task automatic predict(input int tag, input int idx, input bit we,
                          input int fd, input int wd, output exp_t e);
      int  w;
      bit  wb;
      w = -1; wb = 0;
      e.nph = 0; e.ph0 = 0; e.ph1 = 0; e.seq = 0;
      for (int i = 0; i < 8; i++) if (w < 0 && rv[idx][i] && rt[idx][i] == tag) w = i;
      if (w >= 0) begin
         e.hit = 1;
         if (we) rd[idx][w] = 1;
         if (ref_hit < CMAX) ref_hit++;
      end else begin
         e.hit = 0;
         w = ord[idx][0];
         wb = rv[idx][w] && rd[idx][w];
         if (wb) begin e.ph0 = (1 << 12) | (rt[idx][w] << 4) | idx; e.nph = 1; end
         if (e.nph == 0) e.ph0 = (tag << 4) | idx; else e.ph1 = (tag << 4) | idx;
         e.nph++;
         rv[idx][w] = 1; rt[idx][w] = tag; rd[idx][w] = we;
         if (ref_miss < CMAX) ref_miss++;
         e.seq = 1;
      end
      make_mru(idx, w);
      e.way = w;
      if (we) e.seq = e.seq * 4 + 2;
      e.seq = e.seq * 4 + 3;
      e.lat = 4 + int'(we) + (e.hit ? 0 : 1 + fd + (wb ? wd : 0));
      e.hc = ref_hit; e.mc = ref_miss;
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit in_op = 0;
   int m_lat, m_seq, m_ovl, m_nph, m_ph0, m_ph1, m_last_ph;
   bit m_last_req;
   int way_log[$];

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_op = 0;
         end else begin
            if (cpu_busy && !in_op) begin
               in_op = 1; m_lat = 0; m_seq = 0; m_ovl = 0;
               m_nph = 0; m_ph0 = 0; m_ph1 = 0; m_last_req = 0; m_last_ph = 0;
            end
            if (in_op) begin
               int cur;
               m_lat++;
               if (int'(tm_wr) + int'(tm_mod) + int'(tm_age) > 1) m_ovl++;
               if (tm_wr)  m_seq = m_seq * 4 + 1;
               if (tm_mod) m_seq = m_seq * 4 + 2;
               if (tm_age) m_seq = m_seq * 4 + 3;
               cur = (int'(mem_we) << 12) | int'(mem_addr);
               if (mem_req && (!m_last_req || cur != m_last_ph)) begin
                  if (m_nph == 0) m_ph0 = cur; else if (m_nph == 1) m_ph1 = cur;
                  m_nph++;
               end
               m_last_req = mem_req; m_last_ph = cur;
               if (cpu_done) begin
                  in_op = 0;
                  way_log.push_back(int'(cpu_way));
                  if (exp_q.size() == 0) begin
                     chk("unexpected_done", 1, 0);
                  end else begin
                     exp_t e;
                     e = exp_q.pop_front();
                     chk("cpu_hit",   int'(cpu_hit), e.hit);
                     chk("cpu_way",   int'(cpu_way), e.way);
                     chk("latency",   m_lat, e.lat);
                     chk("pulse_seq", m_seq, e.seq);
                     chk("pulse_overlap", m_ovl, 0);
                     chk("mem_phases", m_nph, e.nph);
                     chk("mem_phase0", m_ph0, e.ph0);
                     chk("mem_phase1", m_ph1, e.ph1);
                     chk("hit_cnt",   int'(hit_cnt), e.hc);
                     chk("miss_cnt",  int'(miss_cnt), e.mc);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input int tag, input int idx, input bit we, input int fd,
                        input int wd, input bit hold, input bit chk_gap);
      exp_t e;
      int   n, g;
      predict(tag, idx, we, fd, wd, e);
      exp_q.push_back(e);
      fill_d = fd; wb_d = wd;
      cpu_addr = 12'((tag << 4) | idx);
      cpu_we = we;
      cpu_req = 1'b1;
      n = 0;
      while (cpu_busy && n < 50) begin @(negedge clk); n++; end
      g = 0;
      while (!cpu_busy && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) chk("accept_timeout", 1, 0);
      if (chk_gap) chk("idle_gap", g, 1);
      if (!hold) cpu_req = 1'b0;
      n = 0;
      while (!cpu_done && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) chk("done_timeout", 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, mask, k, lt, li;
      bit  prev_hold;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'd0;
      ref_init();
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(cpu_busy), 0);
      chk("rst_done", int'(cpu_done), 0);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_pulses", int'(tm_wr) + int'(tm_mod) + int'(tm_age), 0);
      chk("rst_hit_cnt", int'(hit_cnt), 0);
      chk("rst_miss_cnt", int'(miss_cnt), 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a fill
      fill_d = 50;
      cpu_addr = 12'h332; cpu_we = 1'b0; cpu_req = 1'b1;
      n = 0;
      while (!cpu_busy && n < 20) begin @(negedge clk); n++; end
      cpu_req = 1'b0;
      n = 0;
      while (!(mem_req && !mem_we) && n < 20) begin @(negedge clk); n++; end
      chk("midfill_req", int'(mem_req), 1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midfill_req_drop", int'(mem_req), 0);
      chk("midfill_busy_drop", int'(cpu_busy), 0);
      chk("midfill_miss_clr", int'(miss_cnt), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", int'(cpu_busy), 0);
      chk("post_rst_mem_req", int'(mem_req), 0);

      // Cold fill, set F, tags 1..8
      for (int t = 1; t <= 8; t++) issue(t, 15, 1'b0, 2, 1, 1'b0, 1'b0);
      @(negedge clk);
      chk("cold_miss_cnt", int'(miss_cnt), 8);
      chk("cold_hit_cnt", int'(hit_cnt), 0);
      mask = 0;
      for (int i = 0; i < 8; i++) mask |= (1 << way_log[way_log.size() - 8 + i]);
      chk("cold_ways_distinct", mask, 255);

      issue(5, 15, 1'b0, 1, 1, 1'b0, 1'b0);      // read hit
      issue(6, 15, 1'b1, 1, 1, 1'b0, 1'b0);      // write hit
      for (int t = 1; t <= 8; t++) issue(t, 15, 1'b1, 1, 1, 1'b0, 1'b0);
      issue(9, 15, 1'b0, 2, 2, 1'b0, 1'b0);      // dirty victim (tag 1)

      // Randomised traffic, cpu_req sometimes held across accesses
      prev_hold = 0;
      for (int i = 0; i < 120; i++) begin
         int tag, idx, gap;
         bit we, hold;
         tag  = int'($urandom_range(1, 12));
         idx  = int'($urandom_range(0, 4));
         if (idx == 4) idx = 15;
         we   = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 1));
         gap  = int'($urandom_range(0, 2));
         if (!prev_hold) begin
            cpu_req = 1'b0;
            repeat (gap) @(negedge clk);
         end
         issue(tag, idx, we, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
               hold, prev_hold);
         prev_hold = hold;
      end
      cpu_req = 1'b0;
      @(negedge clk);

      // Drive both counters into saturation
      k = 0; lt = 128; li = 8;
      while (ref_miss < CMAX && k < 120) begin
         lt = 128 + k; li = 8 + (k % 4);
         issue(lt, li, 1'b0, 1, 1, 1'b0, 1'b0);
         k++;
      end
      issue(250, 12, 1'b0, 1, 1, 1'b0, 1'b0);
      @(negedge clk);
      chk("miss_saturated", int'(miss_cnt), CMAX);
      k = 0;
      while (ref_hit < CMAX && k < 120) begin
         issue(lt, li, 1'b0, 1, 1, 1'b0, 1'b0);
         k++;
      end
      issue(lt, li, 1'b0, 1, 1, 1'b0, 1'b0);
      @(negedge clk);
      chk("hit_saturated", int'(hit_cnt), CMAX);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
